// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

  // Sequencer states: waiting for operands, shifting bits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter width: enough to count WIDTH bits, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return ($clog2(width) < 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit full adder cell, time-multiplexed by the serial sequencer.
module serial_adder_ctrl_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: {co_o, sum_o} = a_i + b_i + ci_i, one bit per
// cycle LSB first, through a single full adder cell.
// Optional macro SERIAL_ADDER_SUB_EN adds a sub_i port selecting a_i - b_i
// (co_o = 1 means no borrow).
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             ci_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             busy_o
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] b_load;
  logic             ci_load;
  logic             fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction is a + ~b + 1: invert B and force the carry-in.
  assign b_load  = sub_i ? ~b_i : b_i;
  assign ci_load = sub_i ? 1'b1 : ci_i;
`else
  assign b_load  = b_i;
  assign ci_load = ci_i;
`endif

  serial_adder_ctrl_full_adder u_fa (
    .a  (op_a_q[0]),
    .b  (op_b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and output decode from the current state.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_d = BUSY;
      end
      BUSY: begin
        busy_o = 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, carry, result and counter datapath.
  // NOTE: the datapath registers are reset too, because sum_o/co_o are driven
  // straight from them and must read zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            op_a_q  <= a_i;
            op_b_q  <= b_load;
            carry_q <= ci_load;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          op_a_q   <= op_a_q >> 1;
          op_b_q   <= op_b_q >> 1;
          result_q <= (result_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          carry_q  <= fa_co;
          cnt_q    <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign sum_o = result_q;
  assign co_o  = carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a WIDTH=16 instance driven with
// directed and random operations, plus a WIDTH=1 instance.
module tb_serial_adder_ctrl;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance signals
  logic         in_valid, in_ready, out_valid, out_ready, ci, co, busy, sub;
  logic [W-1:0] a, b, sum;

  // WIDTH=1 instance signals
  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_ci, w1_co, w1_busy;
  logic [0:0] w1_a, w1_b, w1_sum;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .a_i         (a),
    .b_i         (b),
    .ci_i        (ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i       (sub),
`endif
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .sum_o       (sum),
    .co_o        (co),
    .busy_o      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut_w1 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (w1_in_valid),
    .in_ready_o  (w1_in_ready),
    .a_i         (w1_a),
    .b_i         (w1_b),
    .ci_i        (w1_ci),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i       (1'b0),
`endif
    .out_valid_o (w1_out_valid),
    .out_ready_i (1'b1),
    .sum_o       (w1_sum),
    .co_o        (w1_co),
    .busy_o      (w1_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands, {carry/no-borrow, sum}.
  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mci, input logic msub);
    logic [W:0] r;
    if (msub) begin
      r[W-1:0] = ma - mb;
      r[W]     = (ma >= mb);
    end else begin
      r = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mci};
    end
    return r;
  endfunction

  // Wait (bounded) until the block is idle, at a falling edge.
  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", 64'(t), 64'd0);
  endtask

  // Accept an op at the next rising edge; returns after that edge.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub);
    wait_idle();
    in_valid = 1'b1;
    a = ta; b = tb; ci = tci; sub = tsub;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); ci = 1'($urandom); sub = 1'($urandom);
  endtask

  // Full operation: accept, measure latency, check result, hold in DONE for
  // `hold` cycles with stray requests, then hand off.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tci, input logic tsub, input int hold);
    logic [W:0] exp;
    int lat;
`ifdef SERIAL_ADDER_SUB_EN
    exp = model(ta, tb, tci, tsub);
`else
    exp = model(ta, tb, tci, 1'b0);
`endif
    accept(ta, tb, tci, tsub);
    check("busy_after_accept", {63'd0, busy}, 64'd1);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    lat--;
    check("latency", 64'(lat), 64'(W));
    check("sum", 64'(sum), 64'(exp[W-1:0]));
    check("co", {63'd0, co}, {63'd0, exp[W]});
    check("in_ready_done", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_sum", 64'(sum), 64'(exp[W-1:0]));
      check("hold_co", {63'd0, co}, {63'd0, exp[W]});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("handoff_in_ready", {63'd0, in_ready}, 64'd1);
    check("handoff_valid", {63'd0, out_valid}, 64'd0);
    check("handoff_busy", {63'd0, busy}, 64'd0);
  endtask

  // WIDTH=1 op: consumer always ready, so DONE lasts one cycle.
  task automatic run_op1(input logic ta, input logic tb, input logic tci);
    int lat;
    int t = 0;
    logic [1:0] exp;
    exp = 2'(ta) + 2'(tb) + 2'(tci);
    @(negedge clk);
    while (!w1_in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    w1_in_valid = 1'b1;
    w1_a = ta; w1_b = tb; w1_ci = tci;
    @(posedge clk);
    #1;
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w1_latency", 64'(lat), 64'd1);
    check("w1_sum", 64'(w1_sum), {63'd0, exp[0]});
    check("w1_co", {63'd0, w1_co}, {63'd0, exp[1]});
  endtask

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    w1_in_valid = 1'b0; w1_a = '0; w1_b = '0; w1_ci = 1'b0;
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_co", {63'd0, co}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h1234, 16'h0101, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 5);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 2);

    // Reset in the middle of BUSY: outputs return to reset values at once.
    accept(16'hBEEF, 16'h1111, 1'b1, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_co", {63'd0, co}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1);
`endif

    for (int i = 0; i < 20; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_op1(v[2], v[1], v[0]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
